// File: rtl/apb_pkg.sv
// Shared types and helpers for the core-bus to APB bridge and its lane aligner.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        ERR
    } apb_state_e;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic is_illegal_f3(input logic [2:0] strb);
        return !(strb inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    endfunction

    function automatic logic is_misaligned(input logic [2:0] strb, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (strb)
            F3_H, F3_HU: mis = off[0];
            F3_W:        mis = (off != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/apb_lane_align.sv
// Byte-lane steering: store replication/strobes and load extract with sign/zero extension.
module apb_lane_align
    import apb_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  strb_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] prdata_i,
    output logic [31:0] pwdata_o,
    output logic [3:0]  pstrb_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;
    logic        sext;

    always_comb begin
        shifted  = prdata_i >> {off_i, 3'b000};
        sext     = ~strb_i[2];
        pwdata_o = wdata_i;
        pstrb_o  = 4'b0000;
        rdata_o  = shifted;
        case (strb_i)
            F3_B, F3_BU: begin
                pwdata_o = {4{wdata_i[7:0]}};
                pstrb_o  = 4'b0001 << off_i;
                rdata_o  = {{24{sext & shifted[7]}}, shifted[7:0]};
            end
            F3_H, F3_HU: begin
                pwdata_o = {2{wdata_i[15:0]}};
                pstrb_o  = 4'b0011 << off_i;
                rdata_o  = {{16{sext & shifted[15]}}, shifted[15:0]};
            end
            F3_W: begin
                pwdata_o = wdata_i;
                pstrb_o  = 4'b1111;
                rdata_o  = shifted;
            end
            default: begin
                pstrb_o = 4'b0000;
            end
        endcase
        // Reads never assert byte strobes
        if (!we_i) begin
            pstrb_o = 4'b0000;
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Core data bus to APB3 master: decode, SETUP/ACCESS sequencing, wait states and timeout.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 4,
    parameter logic [31:0] SLV_BASE   = 32'h1000_0000,
    parameter logic [31:0] SLV_SIZE   = 32'h0000_1000,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       transfer,
    input  logic                       busWe,
    input  logic [31:0]                busAddr,
    input  logic [31:0]                busWData,
    input  logic [2:0]                 strb,
    output logic [31:0]                busRData,
    output logic                       ready,
    output logic                       error,
    output logic [31:0]                PADDR,
    output logic                       PWRITE,
    output logic [31:0]                PWDATA,
    output logic [3:0]                 PSTRB,
    output logic [NUM_SLAVES-1:0]      PSEL,
    output logic                       PENABLE,
    input  logic [NUM_SLAVES*32-1:0]   PRDATA,
    input  logic [NUM_SLAVES-1:0]      PREADY
);

    localparam int unsigned IdxW     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned SizeLog2 = $clog2(SLV_SIZE);
    localparam int unsigned CntW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    apb_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     addr_q, wdata_q;
    logic            we_q;
    logic [2:0]      strb_q;
    logic [IdxW-1:0] idx_q;

    logic [32:0]     rel;
    logic [32:0]     idx_wide;
    logic            hit, bad, accept;
    logic [31:0]     prdata_k, ld_data;
    logic            pready_k, psel_en, ld_valid;

    // 33-bit subtract: a borrow into bit 32 means the address lies below the base
    always_comb begin
        rel      = {1'b0, busAddr} - {1'b0, SLV_BASE};
        idx_wide = rel >> SizeLog2;
        hit      = !rel[32] && (idx_wide < 33'(NUM_SLAVES));
        bad      = !hit || is_illegal_f3(strb) || is_misaligned(strb, busAddr[1:0]);
        accept   = (state_q == IDLE) && transfer;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            strb_q  <= '0;
            idx_q   <= '0;
        end else if (accept) begin
            addr_q  <= busAddr;
            wdata_q <= busWData;
            we_q    <= busWe;
            strb_q  <= strb;
            idx_q   <= idx_wide[IdxW-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        prdata_k = '0;
        pready_k = 1'b0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (idx_q == IdxW'(k)) begin
                prdata_k = PRDATA[32*k +: 32];
                pready_k = PREADY[k];
            end
        end
    end

    apb_lane_align u_lane_align (
        .we_i     (we_q),
        .strb_i   (strb_q),
        .off_i    (addr_q[1:0]),
        .wdata_i  (wdata_q),
        .prdata_i (prdata_k),
        .pwdata_o (PWDATA),
        .pstrb_o  (PSTRB),
        .rdata_o  (ld_data)
    );

    assign PADDR  = addr_q;
    assign PWRITE = we_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready    = 1'b0;
        error    = 1'b0;
        PENABLE  = 1'b0;
        psel_en  = 1'b0;
        ld_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    if (bad) begin
                        state_d = ERR;
                    end else begin
                        state_d = SETUP;
                        cnt_d   = '0;
                    end
                end
            end
            SETUP: begin
                psel_en = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                psel_en = 1'b1;
                PENABLE = 1'b1;
                if (pready_k) begin
                    ready    = 1'b1;
                    ld_valid = 1'b1;
                    state_d  = IDLE;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    ready   = 1'b1;
                    error   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            ERR: begin
                ready   = 1'b1;
                error   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busRData = ld_valid ? ld_data : 32'h0;

        PSEL = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            PSEL[k] = psel_en && (idx_q == IdxW'(k));
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: transaction-level model plus per-cycle compare.
module tb_apb_master_bridge;
    import apb_pkg::*;

    localparam int unsigned N    = 4;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] SIZE = 32'h0000_1000;
    localparam int unsigned TO   = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            transfer, busWe;
    logic [31:0]     busAddr, busWData;
    logic [2:0]      strb;
    logic [31:0]     busRData;
    logic            ready, error;
    logic [31:0]     PADDR, PWDATA;
    logic            PWRITE, PENABLE;
    logic [3:0]      PSTRB;
    logic [N-1:0]    PSEL;
    logic [N*32-1:0] PRDATA;
    logic [N-1:0]    PREADY;

    int checks = 0;
    int errors = 0;

    // Expected per-cycle outputs, written by the stimulus process
    logic        chk_en = 1'b0;
    logic        apb_chk, rd_chk;
    logic [3:0]  exp_psel, exp_pstrb;
    logic        exp_pen, exp_ready, exp_error, exp_pwrite;
    logic [31:0] exp_paddr, exp_pwdata, exp_rdata;

    logic [31:0] cap_rdata, cap_pwdata;
    logic [3:0]  cap_pstrb, cap_psel;
    logic        cap_ready, cap_error;

    always #5 clk = ~clk;

    apb_master_bridge #(
        .NUM_SLAVES (N),
        .SLV_BASE   (BASE),
        .SLV_SIZE   (SIZE),
        .TIMEOUT    (TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .transfer (transfer),
        .busWe    (busWe),
        .busAddr  (busAddr),
        .busWData (busWData),
        .strb     (strb),
        .busRData (busRData),
        .ready    (ready),
        .error    (error),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PSTRB    (PSTRB),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("psel", 32'(PSEL), 32'(exp_psel));
            check("penable", 32'(PENABLE), 32'(exp_pen));
            check("ready", 32'(ready), 32'(exp_ready));
            check("error", 32'(error), 32'(exp_error));
            if (apb_chk) begin
                check("paddr", PADDR, exp_paddr);
                check("pwrite", 32'(PWRITE), 32'(exp_pwrite));
                check("pwdata", PWDATA, exp_pwdata);
                check("pstrb", 32'(PSTRB), 32'(exp_pstrb));
            end
            if (rd_chk) begin
                check("busrdata", busRData, exp_rdata);
            end
        end
    end

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return 1;
            F3_H, F3_HU: return 2;
            F3_W:        return 4;
            default:     return 0;
        endcase
    endfunction

    task automatic exp_idle();
        exp_psel  = '0;
        exp_pen   = 1'b0;
        exp_ready = 1'b0;
        exp_error = 1'b0;
        apb_chk   = 1'b0;
        rd_chk    = 1'b0;
    endtask

    task automatic exp_all_zero();
        exp_idle();
        apb_chk    = 1'b1;
        rd_chk     = 1'b1;
        exp_paddr  = '0;
        exp_pwrite = 1'b0;
        exp_pwdata = '0;
        exp_pstrb  = '0;
        exp_rdata  = '0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // One core transaction; waits = ACCESS cycles with PREADY low before it rises (>= TO: never)
    task automatic run(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                       input logic [2:0] f3, input int waits, input logic [31:0] word);
        longint      a, rel, v;
        int          sz, off, idx, n;
        logic        hit, bad, sgn, last;
        logic [31:0] pwd, rd;
        logic [3:0]  ps, onehot;

        a   = longint'(addr);
        sz  = size_of(f3);
        off = int'(addr[1:0]);
        hit = 1'b0;
        idx = 0;
        if (a >= longint'(BASE)) begin
            rel = (a - longint'(BASE)) / longint'(SIZE);
            if (rel < longint'(N)) begin
                hit = 1'b1;
                idx = int'(rel);
            end
        end
        bad = !hit || (sz == 0);
        if (sz != 0 && (off % sz) != 0) bad = 1'b1;

        pwd = '0;
        ps  = '0;
        rd  = '0;
        if (sz != 0) begin
            for (int i = 0; i < 4; i++) begin
                pwd[8*i +: 8] = wd[8*(i % sz) +: 8];
                if (we && i >= off && i < off + sz) ps[i] = 1'b1;
            end
            sgn = (f3 == F3_B) || (f3 == F3_H);
            v   = (longint'(word) >> (8 * off)) % (longint'(1) << (8 * sz));
            if (sgn && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
            rd = v[31:0];
        end
        onehot = 4'(1 << idx);

        transfer = 1'b1;
        busWe    = we;
        busAddr  = addr;
        busWData = wd;
        strb     = f3;
        PREADY   = '0;
        PRDATA   = {N{~word}};
        if (hit) PRDATA[32*idx +: 32] = word;
        exp_idle();
        next_cycle();

        if (bad) begin
            exp_ready = 1'b1;
            exp_error = 1'b1;
            rd_chk    = 1'b1;
            exp_rdata = '0;
            @(negedge clk);
            cap_rdata = busRData;
            cap_ready = ready;
            cap_error = error;
            cap_psel  = 4'(PSEL);
            @(posedge clk);
            #1;
        end else begin
            exp_psel   = onehot;
            apb_chk    = 1'b1;
            exp_paddr  = addr;
            exp_pwrite = we;
            exp_pwdata = pwd;
            exp_pstrb  = ps;
            @(negedge clk);
            cap_psel = 4'(PSEL);
            @(posedge clk);
            #1;
            n = (waits >= int'(TO)) ? int'(TO) : waits + 1;
            for (int j = 0; j < n; j++) begin
                last    = (j == n - 1);
                exp_pen = 1'b1;
                if (waits < int'(TO) && last) begin
                    PREADY    = onehot;
                    exp_ready = 1'b1;
                    exp_error = 1'b0;
                    rd_chk    = !we;
                    exp_rdata = rd;
                end else begin
                    // Other slaves ready while ours stalls: a wrong select would end early
                    PREADY    = ~onehot;
                    exp_ready = last;
                    exp_error = last;
                    rd_chk    = last;
                    exp_rdata = '0;
                end
                @(negedge clk);
                if (last) begin
                    cap_rdata  = busRData;
                    cap_ready  = ready;
                    cap_error  = error;
                    cap_pwdata = PWDATA;
                    cap_pstrb  = PSTRB;
                end
                @(posedge clk);
                #1;
            end
        end

        transfer = 1'b0;
        PREADY   = '0;
        exp_idle();
        next_cycle();
    endtask

    initial begin
        reset    = 1'b1;
        transfer = 1'b0;
        busWe    = 1'b0;
        busAddr  = '0;
        busWData = '0;
        strb     = '0;
        PRDATA   = '0;
        PREADY   = '0;
        exp_all_zero();
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_idle();
        next_cycle();

        // Word store to slave 2
        run(32'h1000_2004, 1'b1, 32'hDEAD_BEEF, F3_W, 0, 32'h0);
        check("sw_psel", 32'(cap_psel), 32'h4);
        check("sw_pwdata", cap_pwdata, 32'hDEAD_BEEF);
        check("sw_pstrb", 32'(cap_pstrb), 32'hF);
        check("sw_ready", 32'(cap_ready), 32'h1);

        // Byte/half loads with extension
        run(32'h1000_0003, 1'b0, 32'h0, F3_B, 0, 32'h8012_3456);
        check("lb_rdata", cap_rdata, 32'hFFFF_FF80);
        run(32'h1000_0003, 1'b0, 32'h0, F3_BU, 0, 32'h8012_3456);
        check("lbu_rdata", cap_rdata, 32'h0000_0080);
        run(32'h1000_0002, 1'b0, 32'h0, F3_HU, 0, 32'h8001_3456);
        check("lhu_rdata", cap_rdata, 32'h0000_8001);
        run(32'h1000_0002, 1'b0, 32'h0, F3_H, 1, 32'h8001_3456);
        check("lh_rdata", cap_rdata, 32'hFFFF_8001);
        run(32'h1000_1001, 1'b0, 32'h0, F3_B, 0, 32'h1122_7F44);
        check("lb_pos_rdata", cap_rdata, 32'h0000_007F);

        // Sub-word stores
        run(32'h1000_1002, 1'b1, 32'h0000_00A5, F3_B, 0, 32'h0);
        check("sb_pwdata", cap_pwdata, 32'hA5A5_A5A5);
        check("sb_pstrb", 32'(cap_pstrb), 32'h4);
        run(32'h1000_1002, 1'b1, 32'h0000_1234, F3_H, 2, 32'h0);
        check("sh_pwdata", cap_pwdata, 32'h1234_1234);
        check("sh_pstrb", 32'(cap_pstrb), 32'hC);

        // Wait states on slave 3
        run(32'h1000_3000, 1'b0, 32'h0, F3_W, 3, 32'hCAFE_F00D);
        check("lw_wait_rdata", cap_rdata, 32'hCAFE_F00D);
        check("lw_wait_psel", 32'(cap_psel), 32'h8);

        // Error responses without APB activity
        run(32'h2000_0000, 1'b0, 32'h0, F3_W, 0, 32'h1234_5678);
        check("unmapped_error", 32'(cap_error), 32'h1);
        check("unmapped_psel", 32'(cap_psel), 32'h0);
        run(32'h1000_0001, 1'b0, 32'h0, F3_H, 0, 32'h1234_5678);
        check("mis_h_error", 32'(cap_error), 32'h1);
        run(32'h1000_0000, 1'b0, 32'h0, 3'b011, 0, 32'h1234_5678);
        check("illegal_f3_error", 32'(cap_error), 32'h1);
        run(32'h1000_0000, 1'b1, 32'h0, 3'b110, 0, 32'h0);
        run(32'h1000_0002, 1'b0, 32'h0, F3_W, 0, 32'h0);
        run(32'h1000_4000, 1'b0, 32'h0, F3_W, 0, 32'h0);
        run(32'h0FFF_FFFC, 1'b0, 32'h0, F3_W, 0, 32'h0);
        run(32'hFFFF_FFFC, 1'b0, 32'h0, F3_W, 0, 32'h0);
        check("top_addr_rdata", cap_rdata, 32'h0);

        // Timeout: PREADY never rises
        run(32'h1000_1008, 1'b0, 32'h0, F3_W, 100, 32'h5555_AAAA);
        check("timeout_ready", 32'(cap_ready), 32'h1);
        check("timeout_error", 32'(cap_error), 32'h1);
        check("timeout_rdata", cap_rdata, 32'h0);

        // Reset asserted mid-ACCESS
        transfer = 1'b1;
        busWe    = 1'b0;
        busAddr  = 32'h1000_1008;
        strb     = F3_W;
        PREADY   = '0;
        exp_idle();
        next_cycle();
        exp_psel = 4'b0010;
        next_cycle();
        exp_pen = 1'b1;
        #2;
        reset    = 1'b1;
        transfer = 1'b0;
        exp_all_zero();
        #1;
        check("async_psel", 32'(PSEL), 32'h0);
        check("async_penable", 32'(PENABLE), 32'h0);
        check("async_ready", 32'(ready), 32'h0);
        next_cycle();
        reset = 1'b0;
        exp_idle();
        next_cycle();
        run(32'h1000_1004, 1'b0, 32'h0, F3_W, 0, 32'h0BAD_F00D);
        check("post_reset_rdata", cap_rdata, 32'h0BAD_F00D);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Bridges the RV32I core's single-request data bus (busWe/busAddr/busWData/strb/busRData) to an APB3 bus with NUM_SLAVES memory-mapped peripherals. It handles:
- address decode;
- the APB SETUP/ACCESS phases;
- per-slave wait states;
- store byte-lane replication and strobes;
- load lane extraction with sign/zero extension;
- error responses for unmapped, misaligned and timed-out accesses.

The core holds its request stable until ready is returned.

Parameters:
- NUM_SLAVES, 4, number of APB slaves (PSEL width).
- SLV_BASE, 32'h1000_0000, base address of slave 0.
- SLV_SIZE, 32'h0000_1000, bytes per slave region; power of two; slave k occupies SLV_BASE+k*SLV_SIZE.
- TIMEOUT, 255, max ACCESS cycles without PREADY before error; must be ≥1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- transfer  input  1  core request valid; held until ready
- busWe  input  1  1=store, 0=load
- busAddr  input  32  byte address
- busWData  input  32  store data, LSB-aligned
- strb  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- busRData  output  32  load result, aligned and extended
- ready  output  1  one-cycle completion pulse
- error  output  1  qualifies ready: access failed
- PADDR  output  32  latched busAddr
- PWRITE  output  1  latched busWe
- PWDATA  output  32  lane-replicated store data
- PSTRB  output  4  byte strobes (all 0 on reads)
- PSEL  output  NUM_SLAVES  one-hot slave select
- PENABLE  output  1  APB access phase
- PRDATA  input  NUM_SLAVES*32  slave k at bits [32k+31:32k]
- PREADY  input  NUM_SLAVES  per-slave ready

Behaviour:
Reset:
- Asynchronous; state goes to IDLE, timeout counter to 0.
- All outputs 0: PSEL, PENABLE, PADDR, PWDATA, PSTRB, PWRITE, ready, error, busRData.
- Reset mid-transfer aborts immediately; no ready is issued.

FSM states: IDLE, SETUP, ACCESS, ERR.
- IDLE: when transfer=1, latch addr, we, wdata, strb and the decoded slave index.
  - Unmapped address, misaligned H (addr[0]=1), misaligned W (addr[1:0]≠0), or illegal strb (011, 11x): go to ERR, with no APB activity.
  - Otherwise go to SETUP.
- SETUP: PSEL[k]=1, PENABLE=0; next state ACCESS.
- ACCESS: PSEL[k]=1, PENABLE=1.
  - If PREADY[k]=1: ready=1 (combinational, this cycle); busRData is driven from PRDATA[k] this cycle; next state IDLE.
  - Else increment counter. When counter reaches TIMEOUT-1 with no PREADY: ready=1, error=1, busRData=0, next state IDLE.
- ERR: ready=1, error=1, busRData=0 for one cycle; next state IDLE.
- PADDR, PWRITE, PWDATA and PSTRB stay stable from SETUP through the final ACCESS cycle.
- Minimum latency: transfer seen in cycle 0, ready in cycle 2. The earliest new request is accepted in cycle 3, since ready returns the FSM to IDLE. The core must hold transfer until ready, and the bridge ignores transfer outside IDLE.
- Counter clears on entry to SETUP.

Decode:
- idx = (addr-SLV_BASE)/SLV_SIZE.
- Hit if addr≥SLV_BASE and idx<NUM_SLAVES.
- Compare in unsigned 33-bit arithmetic, so no wrap at the top of the address space.

Store lanes:
- B: PWDATA={4{wdata[7:0]}}, PSTRB=1<<addr[1:0].
- H: PWDATA={2{wdata[15:0]}}, PSTRB=4'b0011<<addr[1:0].
- W: PWDATA=wdata, PSTRB=4'hF.

Load extract (off=addr[1:0]):
- B/BU: byte at off, sign/zero extended.
- H/HU: half at off, sign/zero extended.
- W: full word.
- error=0 on successful completion.

Decomposition:
- Package apb_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, ERR);
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - a function is_misaligned(strb, addr[1:0]).
- One combinational sub-module, apb_lane_align: store replication and strobe generation, plus load extract and extend. It is reused by a future AXI-lite bridge.
- The top holds the FSM, decode, latches, timeout counter and PRDATA mux.

Test Plan:
1. SW 0x1000_2004, data 0xDEAD_BEEF, PREADY[2]=1 → cycle1 PSEL=4'b0100 PENABLE=0; cycle2 PENABLE=1, PWDATA=0xDEAD_BEEF, PSTRB=4'hF, ready=1, error=0; cycle3 PSEL=0.
2. LB 0x1000_0003, PRDATA[0]=0x80xx_xxxx → busRData=0xFFFF_FF80 with ready. LBU at the same address → 0x0000_0080. LHU 0x1000_0002 with PRDATA=0x8001_xxxx → 0x0000_8001.
3. SB 0x1000_1002, wdata 0x0000_00A5 → PWDATA=0xA5A5_A5A5, PSTRB=4'b0100. SH 0x1000_1002, wdata 0x1234 → PWDATA=0x1234_1234, PSTRB=4'b1100.
4. LW 0x1000_3000 with PREADY[3] low for 3 ACCESS cycles → ready at cycle 5; PADDR/PSEL stable cycles 1–5; no ready before.
5. LW 0x2000_0000 (unmapped), LH 0x1000_0001 (misaligned) and strb=3'b011 → each gives ready=error=1 in cycle 1, PSEL stays 0, busRData=0.
6. TIMEOUT=8, PREADY stuck at 0 → ready=error=1 in the 8th ACCESS cycle, then PSEL=0. Separately, reset asserted during ACCESS → PSEL/PENABLE drop to 0 asynchronously, no ready pulse, and the next transfer after release completes normally.
